y86_execute_stage: RTL and testbench
====================================

Name: y86_execute_stage

Overview:
- Pipelined Execute (E) stage of the Y86-64 processor. Sits between the D/E pipeline register and the Memory stage.
- Selects ALU operands and function per icode/ifun, and drives the team's 64-bit ALU (ALU_64: control 00 add, 01 sub, 10 and, 11 xor; a/b operands; overflow flag).
- Owns the condition-code register (ZF/SF/OF) and evaluates Cnd for jXX/cmovXX.
- Registers results into the E/M pipeline register (1-cycle latency), with stall/bubble control.

Parameters:
- WIDTH, 64, datapath width.
- RNONE, 4'hF, "no register" ID.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- e_valid  in  1  E-stage holds a real instruction.
- e_stat  in  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- e_icode  in  4  instruction code.
- e_ifun  in  4  function code.
- e_valA  in  WIDTH  register operand A.
- e_valB  in  WIDTH  register operand B.
- e_valC  in  WIDTH  constant.
- e_dstE  in  4  destination for valE.
- e_dstM  in  4  destination for valM.
- stall_m  in  1  hold E/M register and CC.
- bubble_m  in  1  load nop into E/M register.
- cc_block  in  1  suppress CC update (downstream exception).
- fwd_valE  out  WIDTH  combinational valE, for decode bypass.
- fwd_dstE  out  4  combinational gated dstE.
- m_valid  out  1  registered valid.
- m_stat  out  2  registered stat.
- m_icode  out  4  registered icode.
- m_cnd  out  1  registered Cnd.
- m_valE  out  WIDTH  registered ALU result.
- m_valA  out  WIDTH  registered valA pass-through.
- m_dstE  out  4  registered gated dstE.
- m_dstM  out  4  registered dstM.
- cc_out  out  3  {ZF,SF,OF}.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - m_valid=0, m_stat=AOK, m_icode=1 (nop), m_cnd=0.
  - m_valE=0, m_valA=0, m_dstE=m_dstM=RNONE.
  - cc_out=3'b100 (ZF=1).
  - rst overrides stall/bubble. Reset mid-stream discards the in-flight instruction.
- Operand/function select (ALU a, b, ctrl) per icode:
  - OPq (6): a=valB, b=valA, ctrl=ifun[1:0] (subq gives valB-valA).
  - rrmovq/cmovXX (2): a=0, b=valA, add.
  - irmovq (3): a=0, b=valC, add.
  - rmmovq/mrmovq (4/5): a=valB, b=valC, add.
  - call/pushq (8/A): a=valB, b=-8, add.
  - ret/popq (9/B): a=valB, b=+8, add.
  - All other icodes: a=0, b=0, add.
- Arithmetic: WIDTH-bit two's complement, wrap-around. Carry out is discarded.
- CC update:
  - Condition: e_valid & icode==6 & e_stat==AOK & !cc_block & !stall_m & !bubble_m.
  - New values: ZF=(valE==0), SF=valE[MSB], OF=ALU overflow. For and/xor, OF=0.
  - Written at the clock edge. Visible to the next instruction.
- Cnd: computed from the current (pre-edge) CC, for icode 2 or 7 only; otherwise 0.
  - ifun 0 always.
  - ifun 1 le: (SF^OF)|ZF.
  - ifun 2 l: SF^OF.
  - ifun 3 e: ZF.
  - ifun 4 ne: !ZF.
  - ifun 5 ge: !(SF^OF).
  - ifun 6 g: !(SF^OF)&!ZF.
  - ifun >6 gives 0.
- Gated dstE: RNONE if icode==2 & !Cnd; otherwise e_dstE. fwd_* are valid only when e_valid=1; fwd_dstE=RNONE otherwise.
- E/M register update priority: rst > stall_m (hold all) > bubble_m (reset values, except m_stat=AOK) > load.
  - On load, m_valid=e_valid. If e_valid=0, load bubble values.
- Latency: 1 cycle E input to m_* outputs.
- Non-AOK e_stat: instruction still propagates (stat carried), but CC is not updated.

Decomposition:
- Shared package y86_pkg:
  - icode constants (IHALT..IPOPQ).
  - ALU control encodings (ALU_ADD/SUB/AND/XOR).
  - stat codes.
  - condition ifun constants.
  - RNONE.
- Natural sub-module: y86_cond_eval (CC + ifun → Cnd, combinational).
- Instantiates existing ALU_64.
- CC register and E/M register live in the top.

Test Plan:
- Reset then idle → m_valid=0, m_icode=1, m_dstE=F, cc_out=3'b100.
- subq (icode 6, ifun 1) valA=52, valB=256, dstE=3 → next cycle m_valE=204, m_dstE=3, cc_out=000.
- addq valA=valB=64'h7FFF_FFFF_FFFF_FFFF → m_valE=64'hFFFF_FFFF_FFFF_FFFE, cc_out=011. Following jl → m_cnd=0; jge → m_cnd=1.
- subq valA=valB=5 (ZF=1), then cmovne dstE=2 valA=9 → m_dstE=F, m_valE=9. cmove → m_dstE=2.
- pushq valB=64'h100 → m_valE=64'hF8, CC unchanged. popq valB=64'hF8 → m_valE=64'h100.
- stall_m=1 and bubble_m=1 with subq loaded → m_* hold, CC unchanged. Then bubble_m alone → m_valid=0, m_icode=1. cc_block=1 on addq → CC unchanged, m_valE still correct.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU controls, status codes and
// condition function codes used by the pipeline stages.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_ctrl_e;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/ALU_64.sv
// Team 64-bit ALU: add/sub/and/xor with signed overflow flag.
module ALU_64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [1:0]       ctrl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o
);

    localparam int unsigned Msb = WIDTH - 1;

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (ctrl_i)
            2'b00: begin
                result_o   = a_i + b_i;
                overflow_o = (a_i[Msb] == b_i[Msb]) && (result_o[Msb] != a_i[Msb]);
            end
            2'b01: begin
                result_o   = a_i - b_i;
                overflow_o = (a_i[Msb] != b_i[Msb]) && (result_o[Msb] != a_i[Msb]);
            end
            2'b10:   result_o = a_i & b_i;
            default: result_o = a_i ^ b_i;
        endcase
    end

endmodule

// File: rtl/y86_cond_eval.sv
// Branch / conditional-move condition evaluation from {ZF,SF,OF} and ifun.
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc_i,
    input  logic [3:0] ifun_i,
    output logic       cnd_o
);

    logic zf, sf, of, lt;

    assign zf = cc_i[2];
    assign sf = cc_i[1];
    assign of = cc_i[0];
    assign lt = sf ^ of;

    always_comb begin
        cnd_o = 1'b0;
        case (ifun_i)
            C_YES:   cnd_o = 1'b1;
            C_LE:    cnd_o = lt | zf;
            C_L:     cnd_o = lt;
            C_E:     cnd_o = zf;
            C_NE:    cnd_o = ~zf;
            C_GE:    cnd_o = ~lt;
            C_G:     cnd_o = ~lt & ~zf;
            default: cnd_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 Execute stage: ALU operand select, condition codes, Cnd and the
// E/M pipeline register with stall/bubble control.
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e_valid,
    input  logic [1:0]       e_stat,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_ifun,
    input  logic [WIDTH-1:0] e_valA,
    input  logic [WIDTH-1:0] e_valB,
    input  logic [WIDTH-1:0] e_valC,
    input  logic [3:0]       e_dstE,
    input  logic [3:0]       e_dstM,
    input  logic             stall_m,
    input  logic             bubble_m,
    input  logic             cc_block,
    output logic [WIDTH-1:0] fwd_valE,
    output logic [3:0]       fwd_dstE,
    output logic             m_valid,
    output logic [1:0]       m_stat,
    output logic [3:0]       m_icode,
    output logic             m_cnd,
    output logic [WIDTH-1:0] m_valE,
    output logic [WIDTH-1:0] m_valA,
    output logic [3:0]       m_dstE,
    output logic [3:0]       m_dstM,
    output logic [2:0]       cc_out
);

    typedef struct packed {
        logic             valid;
        logic [1:0]       stat;
        logic [3:0]       icode;
        logic             cnd;
        logic [WIDTH-1:0] valE;
        logic [WIDTH-1:0] valA;
        logic [3:0]       dstE;
        logic [3:0]       dstM;
    } em_t;

    localparam logic [WIDTH-1:0] Eight = WIDTH'(8);
    localparam em_t EmBubble = '{
        valid: 1'b0, stat: STAT_AOK, icode: INOP, cnd: 1'b0,
        valE: '0, valA: '0, dstE: RNONE, dstM: RNONE
    };

    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    alu_ctrl_e        alu_ctrl;
    logic             alu_ovf;
    logic             cnd_raw, cnd, cc_upd;
    logic [3:0]       dste_gated;
    logic [2:0]       cc_q, cc_d;
    em_t              em_q, em_d;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        case (e_icode)
            IOPQ: begin
                alu_a    = e_valB;
                alu_b    = e_valA;
                alu_ctrl = alu_ctrl_e'(e_ifun[1:0]);
            end
            IRRMOVQ: alu_b = e_valA;
            IIRMOVQ: alu_b = e_valC;
            IRMMOVQ, IMRMOVQ: begin
                alu_a = e_valB;
                alu_b = e_valC;
            end
            ICALL, IPUSHQ: begin
                alu_a = e_valB;
                alu_b = -Eight;
            end
            IRET, IPOPQ: begin
                alu_a = e_valB;
                alu_b = Eight;
            end
            default: ;
        endcase
    end

    ALU_64 #(
        .WIDTH (WIDTH)
    ) u_alu (
        .ctrl_i     (alu_ctrl),
        .a_i        (alu_a),
        .b_i        (alu_b),
        .result_o   (alu_res),
        .overflow_o (alu_ovf)
    );

    y86_cond_eval u_cond (
        .cc_i   (cc_q),
        .ifun_i (e_ifun),
        .cnd_o  (cnd_raw)
    );

    assign cnd        = ((e_icode == IRRMOVQ) || (e_icode == IJXX)) ? cnd_raw : 1'b0;
    assign dste_gated = ((e_icode == IRRMOVQ) && !cnd) ? RNONE : e_dstE;

    assign fwd_valE = alu_res;
    assign fwd_dstE = e_valid ? dste_gated : RNONE;

    // CC only tracks OPq results that will actually retire into the E/M register.
    assign cc_upd = e_valid && (e_icode == IOPQ) && (e_stat == STAT_AOK)
                    && !cc_block && !stall_m && !bubble_m;

    always_comb begin
        cc_d = cc_q;
        if (cc_upd) begin
            cc_d = {(alu_res == '0), alu_res[WIDTH-1], alu_ovf};
        end
    end

    always_comb begin
        em_d = em_q;
        if (!stall_m) begin
            if (bubble_m || !e_valid) begin
                em_d = EmBubble;
            end else begin
                em_d = '{
                    valid: 1'b1, stat: e_stat, icode: e_icode, cnd: cnd,
                    valE: alu_res, valA: e_valA, dstE: dste_gated, dstM: e_dstM
                };
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            em_q <= EmBubble;
            cc_q <= 3'b100;
        end else begin
            em_q <= em_d;
            cc_q <= cc_d;
        end
    end

    assign m_valid = em_q.valid;
    assign m_stat  = em_q.stat;
    assign m_icode = em_q.icode;
    assign m_cnd   = em_q.cnd;
    assign m_valE  = em_q.valE;
    assign m_valA  = em_q.valA;
    assign m_dstE  = em_q.dstE;
    assign m_dstM  = em_q.dstM;
    assign cc_out  = cc_q;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Scoreboard bench for y86_execute_stage: driver queues hand-computed E/M
// results, monitor pops and compares one entry per clock.
module tb_y86_execute_stage;

    typedef struct {
        logic        valid;
        logic [1:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [2:0]  cc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        e_valid;
    logic [1:0]  e_stat;
    logic [3:0]  e_icode, e_ifun;
    logic [63:0] e_valA, e_valB, e_valC;
    logic [3:0]  e_dstE, e_dstM;
    logic        stall_m, bubble_m, cc_block;
    logic [63:0] fwd_valE;
    logic [3:0]  fwd_dstE;
    logic        m_valid;
    logic [1:0]  m_stat;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_valE, m_valA;
    logic [3:0]  m_dstE, m_dstM;
    logic [2:0]  cc_out;

    exp_t exp_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   passes = 0;

    y86_execute_stage #(
        .WIDTH (64),
        .RNONE (4'hF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .e_valid  (e_valid),
        .e_stat   (e_stat),
        .e_icode  (e_icode),
        .e_ifun   (e_ifun),
        .e_valA   (e_valA),
        .e_valB   (e_valB),
        .e_valC   (e_valC),
        .e_dstE   (e_dstE),
        .e_dstM   (e_dstM),
        .stall_m  (stall_m),
        .bubble_m (bubble_m),
        .cc_block (cc_block),
        .fwd_valE (fwd_valE),
        .fwd_dstE (fwd_dstE),
        .m_valid  (m_valid),
        .m_stat   (m_stat),
        .m_icode  (m_icode),
        .m_cnd    (m_cnd),
        .m_valE   (m_valE),
        .m_valA   (m_valA),
        .m_dstE   (m_dstE),
        .m_dstM   (m_dstM),
        .cc_out   (cc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: one expected entry per clock, sampled after the edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_valid", 64'(m_valid), 64'(e.valid));
                chk("m_stat",  64'(m_stat),  64'(e.stat));
                chk("m_icode", 64'(m_icode), 64'(e.icode));
                chk("m_cnd",   64'(m_cnd),   64'(e.cnd));
                chk("m_valE",  m_valE,       e.valE);
                chk("m_valA",  m_valA,       e.valA);
                chk("m_dstE",  64'(m_dstE),  64'(e.dstE));
                chk("m_dstM",  64'(m_dstM),  64'(e.dstM));
                chk("cc_out",  64'(cc_out),  64'(e.cc));
            end
        end
    end

    task automatic drv(input logic r, input logic v, input logic [1:0] st,
                       input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic stl, input logic bub, input logic ccb);
        rst = r; e_valid = v; e_stat = st; e_icode = ic; e_ifun = fn;
        e_valA = a; e_valB = b; e_valC = c; e_dstE = de; e_dstM = dm;
        stall_m = stl; bubble_m = bub; cc_block = ccb;
    endtask

    task automatic expect_em(input logic v, input logic [1:0] st, input logic [3:0] ic,
                             input logic cn, input logic [63:0] ve, input logic [63:0] va,
                             input logic [3:0] de, input logic [3:0] dm, input logic [2:0] cc);
        exp_t e;
        e = '{valid: v, stat: st, icode: ic, cnd: cn, valE: ve, valA: va,
              dstE: de, dstM: dm, cc: cc};
        last_exp = e;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    localparam logic [63:0] MaxPos = 64'h7FFF_FFFF_FFFF_FFFF;

    initial begin
        drv(1, 0, 0, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0);
        @(negedge clk);
        // reset and idle
        drv(1, 0, 0, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0);
        expect_em(0, 0, 4'h1, 0, 0, 0, 4'hF, 4'hF, 3'b100);
        drv(0, 0, 0, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0);
        expect_em(0, 0, 4'h1, 0, 0, 0, 4'hF, 4'hF, 3'b100);
        // subq 256-52
        drv(0, 1, 0, 4'h6, 4'h1, 64'd52, 64'd256, 0, 4'h3, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h6, 0, 64'd204, 64'd52, 4'h3, 4'hF, 3'b000);
        // addq overflow, then jl / jge
        drv(0, 1, 0, 4'h6, 4'h0, MaxPos, MaxPos, 0, 4'h4, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h6, 0, 64'hFFFF_FFFF_FFFF_FFFE, MaxPos, 4'h4, 4'hF, 3'b011);
        drv(0, 1, 0, 4'h7, 4'h2, 0, 0, 64'h40, 4'hF, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h7, 0, 0, 0, 4'hF, 4'hF, 3'b011);
        drv(0, 1, 0, 4'h7, 4'h5, 0, 0, 64'h40, 4'hF, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h7, 1, 0, 0, 4'hF, 4'hF, 3'b011);
        // subq 5-5 sets ZF, then cmovne / cmove
        drv(0, 1, 0, 4'h6, 4'h1, 64'd5, 64'd5, 0, 4'h1, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h6, 0, 0, 64'd5, 4'h1, 4'hF, 3'b100);
        drv(0, 1, 0, 4'h2, 4'h4, 64'd9, 0, 0, 4'h2, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h2, 0, 64'd9, 64'd9, 4'hF, 4'hF, 3'b100);
        drv(0, 1, 0, 4'h2, 4'h3, 64'd9, 0, 0, 4'h2, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h2, 1, 64'd9, 64'd9, 4'h2, 4'hF, 3'b100);
        // pushq / popq
        drv(0, 1, 0, 4'hA, 4'h0, 64'd7, 64'h100, 0, 4'h4, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'hA, 0, 64'hF8, 64'd7, 4'h4, 4'hF, 3'b100);
        drv(0, 1, 0, 4'hB, 4'h0, 64'hF8, 64'hF8, 0, 4'h4, 4'h5, 0, 0, 0);
        expect_em(1, 0, 4'hB, 0, 64'h100, 64'hF8, 4'h4, 4'h5, 3'b100);
        // stall+bubble holds everything
        drv(0, 1, 0, 4'h6, 4'h1, 64'd1, 64'd3, 0, 4'h3, 4'hF, 1, 1, 0);
        exp_q.push_back(last_exp);
        @(negedge clk);
        // bubble alone inserts a nop, CC untouched
        drv(0, 1, 0, 4'h6, 4'h1, 64'd1, 64'd3, 0, 4'h3, 4'hF, 0, 1, 0);
        expect_em(0, 0, 4'h1, 0, 0, 0, 4'hF, 4'hF, 3'b100);
        // cc_block on addq
        drv(0, 1, 0, 4'h6, 4'h0, 64'd1, 64'd2, 0, 4'h6, 4'hF, 0, 0, 1);
        expect_em(1, 0, 4'h6, 0, 64'd3, 64'd1, 4'h6, 4'hF, 3'b100);
        // irmovq
        drv(0, 1, 0, 4'h3, 4'h0, 0, 0, 64'h1234, 4'h7, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h3, 0, 64'h1234, 0, 4'h7, 4'hF, 3'b100);
        // ADR status: propagates but CC unchanged
        drv(0, 1, 2, 4'h6, 4'h1, 64'd1, 64'd3, 0, 4'h3, 4'hF, 0, 0, 0);
        expect_em(1, 2, 4'h6, 0, 64'd2, 64'd1, 4'h3, 4'hF, 3'b100);
        // mrmovq address
        drv(0, 1, 0, 4'h5, 4'h0, 0, 64'h1000, 64'h20, 4'hF, 4'h8, 0, 0, 0);
        expect_em(1, 0, 4'h5, 0, 64'h1020, 0, 4'hF, 4'h8, 3'b100);
        // andq, xorq
        drv(0, 1, 0, 4'h6, 4'h2, 64'h3C, 64'hF0, 0, 4'h9, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h6, 0, 64'h30, 64'h3C, 4'h9, 4'hF, 3'b000);
        drv(0, 1, 0, 4'h6, 4'h3, 64'hFF, 64'hFF, 0, 4'hA, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h6, 0, 0, 64'hFF, 4'hA, 4'hF, 3'b100);
        // subq that would clear ZF, then reset mid-stream discards it
        drv(0, 1, 0, 4'h6, 4'h1, 64'd1, 64'd3, 0, 4'h3, 4'hF, 0, 0, 0);
        expect_em(1, 0, 4'h6, 0, 64'd2, 64'd1, 4'h3, 4'hF, 3'b000);
        drv(1, 1, 0, 4'h6, 4'h0, 64'd1, 64'd3, 0, 4'h3, 4'hF, 1, 0, 0);
        expect_em(0, 0, 4'h1, 0, 0, 0, 4'hF, 4'hF, 3'b100);
        drv(0, 0, 0, 4'h1, 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
